// File: rtl/fetch_if.sv
// fetch_if: fetch-to-imem/decode bus bundle.
// master = fetch unit side, slave = memory/decode side.
interface fetch_if;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign;

  modport master (
    input  run,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_target,
    input  inst_ready,
    output imem_addr,
    output inst_valid,
    output inst,
    output inst_pc,
    output misalign
  );

  modport slave (
    output run,
    output imem_rdata,
    output redirect_valid,
    output redirect_target,
    output inst_ready,
    input  imem_addr,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with a small prefetch FIFO.
// Redirects flush the FIFO and restart at the target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  logic [31:0]   pc;
  logic [AW:0]   count;
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [31:0]   wq [DEPTH];
  logic [31:0]   pq [DEPTH];
  logic          mis;
  logic          deq;
  logic          enq;

  assign deq = bus.inst_valid && bus.inst_ready;
  assign enq = bus.run && !bus.redirect_valid
            && (count < FULL || deq);

  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = wq[rd];
  assign bus.inst_pc    = pq[rd];
  assign bus.misalign   = mis;

  // PC, pointers and occupancy; redirect wins over enq/deq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      count <= '0;
      rd    <= '0;
      wr    <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= {bus.redirect_target[31:2], 2'b00};
      count <= '0;
      rd    <= '0;
      wr    <= '0;
    end else begin
      if (enq) begin
        pc <= pc + 32'd4;
        wr <= wr + PONE;
      end
      if (deq) rd <= rd + PONE;
      case ({enq, deq})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: capture the word returned for the current pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        wq[i] <= '0;
        pq[i] <= '0;
      end
    end else if (enq) begin
      wq[wr] <= bus.imem_rdata;
      pq[wr] <= pc;
    end
  end

  // One-cycle flag for a redirect to a non-word-aligned target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis <= 1'b0;
    else        mis <= bus.redirect_valid
                    && (bus.redirect_target[1:0] != 2'b00);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] key = 32'h0;
  int vec = 0;
  int err = 0;

  logic [31:0] m_pc;
  logic [63:0] mq [$];
  logic        m_mis;

  fetch_if bus ();

  assign bus.imem_rdata =
    ({2'b00, bus.imem_addr[31:2]} + 32'd100) ^ key;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(logic [31:0] a);
    return ({2'b00, a[31:2]} + 32'd100) ^ key;
  endfunction

  task automatic drive(input logic r, input logic rv,
                       input logic [31:0] rt, input logic rdy);
    bus.run = r;
    bus.redirect_valid = rv;
    bus.redirect_target = rt;
    bus.inst_ready = rdy;
  endtask

  task automatic model_reset();
    m_pc = RPC;
    mq.delete();
    m_mis = 1'b0;
  endtask

  // Advance one clock and update the model from the
  // rules: redirect flushes, else pop on accept, push on fetch.
  task automatic tick();
    logic d;
    logic e;
    @(posedge clk);
    d = (mq.size() != 0) && bus.inst_ready;
    if (bus.redirect_valid) begin
      mq.delete();
      m_pc = {bus.redirect_target[31:2], 2'b00};
      m_mis = |bus.redirect_target[1:0];
    end else begin
      m_mis = 1'b0;
      e = bus.run && (mq.size() < DEPTH || d);
      if (d) void'(mq.pop_front());
      if (e) begin
        mq.push_back({m_pc, memw(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (bus.inst_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_valid got=%b exp=0", bus.inst_valid);
    end
    vec++;
    if (bus.imem_addr !== RPC) begin
      err++;
      $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RPC);
    end
    vec++;
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      err++;
      $display("FAIL reset_head got=%h/%h exp=0/0",
               bus.inst, bus.inst_pc);
    end
    vec++;
    if (bus.misalign !== 1'b0) begin
      err++;
      $display("FAIL reset_mis got=%b exp=0", bus.misalign);
    end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      vec++;
      if (bus.inst_valid !== 1'b1
          || bus.inst !== 32'(100 + i)
          || bus.inst_pc !== 32'(4 * i)) begin
        err++;
        $display("FAIL stream%0d got=%b/%h/%h exp=1/%h/%h", i,
                 bus.inst_valid, bus.inst, bus.inst_pc,
                 32'(100 + i), 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if (bus.inst !== 32'd100 || bus.inst_pc !== 32'h0) begin
        err++;
        $display("FAIL bp_hold%0d got=%h/%h exp=%h/0", i,
                 bus.inst, bus.inst_pc, 32'd100);
      end
    end
    vec++;
    if (bus.imem_addr !== RPC + 32'd8) begin
      err++;
      $display("FAIL bp_pc got=%h exp=%h",
               bus.imem_addr, RPC + 32'd8);
    end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin
        err++;
        $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i,
                 bus.inst_valid, bus.inst_pc, 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b1, 1'b1, 32'h20, 1'b1);
    tick();
    vec++;
    if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h20) begin
      err++;
      $display("FAIL redir_bubble got=%b/%h exp=0/20",
               bus.inst_valid, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    vec++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h20
        || bus.inst !== 32'd108) begin
      err++;
      $display("FAIL redir_target got=%b/%h/%h exp=1/20/%h",
               bus.inst_valid, bus.inst_pc, bus.inst, 32'd108);
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 32'h23, 1'b1);
    tick();
    vec++;
    if (bus.misalign !== 1'b1 || bus.imem_addr !== 32'h20) begin
      err++;
      $display("FAIL mis_pulse got=%b/%h exp=1/20",
               bus.misalign, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    vec++;
    if (bus.misalign !== 1'b0 || bus.inst_pc !== 32'h20) begin
      err++;
      $display("FAIL mis_clear got=%b/%h exp=0/20",
               bus.misalign, bus.inst_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    vec++;
    if (bus.inst_pc !== 32'hFFFF_FFFC
        || bus.inst !== 32'h3FFF_FFFF + 32'd100) begin
      err++;
      $display("FAIL wrap_top got=%h/%h exp=fffffffc/%h",
               bus.inst_pc, bus.inst, 32'h3FFF_FFFF + 32'd100);
    end
    tick();
    vec++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
      err++;
      $display("FAIL wrap_zero got=%b/%h exp=1/0",
               bus.inst_valid, bus.inst_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if (bus.inst_valid !== 1'b0 || bus.imem_addr !== RPC) begin
      err++;
      $display("FAIL areset got=%b/%h exp=0/%h",
               bus.inst_valid, bus.imem_addr, RPC);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    vec++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RPC) begin
      err++;
      $display("FAIL areset_first got=%b/%h exp=1/%h",
               bus.inst_valid, bus.inst_pc, RPC);
    end
  endtask

  task automatic test_random();
    logic [63:0] h;
    key = $urandom;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(9) != 0, $urandom_range(7) == 0,
            $urandom, $urandom_range(2) != 0);
      tick();
      h = (mq.size() != 0) ? mq[0] : 64'h0;
      vec++;
      if (bus.inst_valid !== (mq.size() != 0)
          || bus.imem_addr !== m_pc
          || bus.misalign !== m_mis
          || (mq.size() != 0 && (bus.inst !== h[31:0]
              || bus.inst_pc !== h[63:32]))) begin
        err++;
        $display("FAIL rand%0d got=%b/%h/%b/%h/%h exp=%b/%h/%b/%h/%h",
                 i, bus.inst_valid, bus.imem_addr, bus.misalign,
                 bus.inst, bus.inst_pc, mq.size() != 0, m_pc,
                 m_mis, h[31:0], h[63:32]);
      end
    end
    key = 32'h0;
  endtask

  initial begin
    model_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the single-cycle-read instruction memory. Owns the program counter, drives the memory byte address every cycle and captures the returned word into a small prefetch FIFO. Presents instructions to decode with a valid/ready handshake. Redirects (jump/branch) flush the FIFO and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
- DEPTH, 2, prefetch FIFO entries; power of two, 2..8

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; 0 = no new fetches, FIFO still drains
- imem_addr  out  32  byte address to instruction memory (word index = addr/4)
- imem_rdata  in  32  instruction word, combinational from imem_addr in the same cycle
- redirect_valid  in  1  one-cycle request to change PC
- redirect_target  in  32  new byte PC for the redirect
- inst_valid  out  1  FIFO head holds a valid instruction
- inst  out  32  FIFO head instruction word
- inst_pc  out  32  byte PC of inst
- inst_ready  in  1  decode accepts inst this cycle
- misalign  out  1  registered one-cycle pulse: last redirect_target had bits [1:0] != 0

## Operation
- State: pc register (32 b), FIFO of DEPTH entries {word, pc}, count (0..DEPTH), misalign flag.
- imem_addr = pc. It is driven directly from the register with no combinational path from any input.
- deq = inst_valid && inst_ready.
- enq = run && !redirect_valid && (count < DEPTH || deq).
- On enq: push {imem_rdata, pc}; pc <= pc + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
- Simultaneous enq and deq when full: allowed, count unchanged. Push and pop happen in the same cycle, with no bubble.
- Redirect (highest priority):
  - count <= 0 and pc <= {redirect_target[31:2], 2'b00}.
  - No enq that cycle, regardless of run.
  - A deq in the same cycle counts as accepted; the flush then discards everything else.
  - misalign <= |redirect_target[1:0]. misalign is 0 in every cycle not following a redirect.
- inst_valid = (count != 0). inst and inst_pc come from the FIFO head.
- While inst_valid=1 and no deq and no redirect, inst and inst_pc hold stable.
- run=0: pc frozen, no pushes. The FIFO drains normally. Redirects are still honoured.
- Optional debug states are derived from (run, count): IDLE (run=0), FETCH (count<DEPTH), FULL (count=DEPTH). No separate FSM register is required.

## Timing
- Reset (async assert, synchronous-style release on next edge):
  - pc=RESET_PC, count=0.
  - inst_valid=0, misalign=0.
  - imem_addr=RESET_PC, inst=0, inst_pc=0.
- Fetch latency: a word whose address is on imem_addr in cycle N appears as the FIFO head with inst_valid=1 in cycle N+1 (FIFO initially empty).
- Steady state with inst_ready=1 and run=1: one instruction per cycle, consecutive PCs.
- Redirect sampled at edge E:
  - imem_addr = target in cycle E+1.
  - Target instruction valid in cycle E+2.
  - Exactly one bubble cycle, with inst_valid=0.
- misalign is valid in the cycle after the redirect edge.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. Any in-flight FIFO contents are lost.

## Test plan
- Reset then run=1, inst_ready=1, mem[k]=k+100:
  - Cycle 1 shows inst=100, inst_pc=0.
  - Following cycles show 101/4, 102/8, … with no gaps.
- Backpressure: inst_ready=0 for 5 cycles with DEPTH=2.
  - count saturates at 2 and pc stops at RESET_PC+8.
  - inst holds mem[0].
  - After ready returns, outputs are 0, 4, 8 in order with no duplicates or skips.
- Redirect with simultaneous deq, FIFO full:
  - redirect_target=32'h20 and inst_ready=1 in the same cycle.
  - Next cycle inst_valid=0. Cycle after: inst_pc=32'h20, inst=mem[8].
- Misaligned redirect to 32'h23:
  - misalign=1 for exactly one cycle.
  - Fetch resumes at 32'h20.
- Wrap: redirect to 32'hFFFF_FFFC, then run.
  - Two consecutive outputs have inst_pc FFFF_FFFC then 0000_0000.
- Mid-run async reset with FIFO non-empty:
  - inst_valid drops to 0 before the next clk edge.
  - After release, the first output has inst_pc=RESET_PC.
